// File: rtl/axi4_burst_mem.sv
// rtl/axi4_burst_mem.sv - AXI4 burst slave memory (FIXED/INCR, strobes, per-beat SLVERR)
// Purpose: simulation main memory behind the AXI4 crossbar. It serves one read or
//   write burst at a time. When both are requested together, priority alternates.
// Ports: clk, rst (asynchronous, active-high);
//   AR/R : arid/araddr/arlen/arsize/arburst/arvalid/arready, rid/rdata/rresp/rlast/rvalid/rready
//   AW/W/B: awid/awaddr/awlen/awsize/awburst/awvalid/awready, wdata/wstrb/wlast/wvalid/wready,
//           bid/bresp/bvalid/bready
module axi4_burst_mem #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                ID_W     = 4,
  parameter int                DEPTH    = 4096,
  parameter logic [ADDR_W-1:0] BASE     = ADDR_W'(32'h8000_0000),
  parameter int                READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);
  localparam int                BYTES   = DATA_W / 8;
  localparam int                LG      = (DATA_W == 64) ? 3 : 2;
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]        SIZE_OK = 3'(LG);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(BYTES);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

  state_t              state_q, state_d;
  logic                prio_rd;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q, addr_nxt, fetch_addr;
  logic [7:0]          len_q;
  logic [1:0]          burst_q, fetch_burst;
  logic [2:0]          size_q, fetch_size;
  logic [8:0]          beat_q;
  logic [3:0]          lat_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q, fetch_word;
  logic [1:0]          rresp_q;
  logic                grant_rd, ar_hs, aw_hs, r_hs, w_hs;
  logic                load_rd, rd_last, beat_over, fetch_bad, wr_bad, wr_en;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Error for one beat: out of window, WRAP/reserved burst, or narrow/wide size.
  function automatic logic beat_bad(input logic [ADDR_W-1:0] a, input logic [1:0] b,
                                    input logic [2:0] s);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a < BASE) || ((off >> LG) >= DEPTH_A) || (b != 2'b00 && b != 2'b01) ||
           (s != SIZE_OK);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE) >> LG);
  endfunction

  assign grant_rd  = arvalid && (!awvalid || prio_rd);
  assign ar_hs     = arvalid && arready;
  assign aw_hs     = awvalid && awready;
  assign r_hs      = rvalid && rready;
  assign w_hs      = wvalid && wready;
  assign rd_last   = (beat_q == {1'b0, len_q});
  assign beat_over = (beat_q > {1'b0, len_q});
  assign addr_nxt  = (burst_q == 2'b01) ? addr_q + STEP : addr_q;

  // Address whose word is loaded into rdata_q this cycle: the incoming AR in IDLE
  // (zero latency), the following beat in RD_DATA (zero latency), else the latched one.
  always_comb begin
    fetch_addr  = addr_q;
    fetch_burst = burst_q;
    fetch_size  = size_q;
    if (state_q == IDLE) begin
      fetch_addr  = araddr;
      fetch_burst = arburst;
      fetch_size  = arsize;
    end else if (state_q == RD_DATA) begin
      fetch_addr = addr_nxt;
    end
  end

  assign fetch_bad  = beat_bad(fetch_addr, fetch_burst, fetch_size);
  assign fetch_word = mem[word_idx(fetch_addr)];
  assign wr_bad     = beat_bad(addr_q, burst_q, size_q);
  assign wr_en      = w_hs && !beat_over && !wr_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    bvalid  = 1'b0;
    load_rd = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by rst so every output is low while reset is held.
        arready = !rst && grant_rd;
        awready = !rst && !grant_rd;
        if (arvalid && arready) begin
          load_rd = (READ_LAT == 0);
          state_d = (READ_LAT == 0) ? RD_DATA : RD_WAIT;
        end else if (awvalid && awready) begin
          state_d = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (lat_q == 4'(READ_LAT - 1)) begin
          load_rd = 1'b1;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (rready) begin
          if (rd_last)             state_d = IDLE;
          else if (READ_LAT == 0)  load_rd = 1'b1;
          else                     state_d = RD_WAIT;
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) state_d = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_rd <= 1'b1;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      burst_q <= '0;
      size_q  <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      if (ar_hs) begin
        id_q    <= arid;
        addr_q  <= araddr;
        len_q   <= arlen;
        burst_q <= arburst;
        size_q  <= arsize;
        beat_q  <= '0;
        lat_q   <= '0;
        prio_rd <= ~prio_rd;
      end
      if (aw_hs) begin
        id_q    <= awid;
        addr_q  <= awaddr;
        len_q   <= awlen;
        burst_q <= awburst;
        size_q  <= awsize;
        beat_q  <= '0;
        err_q   <= 1'b0;
        prio_rd <= ~prio_rd;
      end
      if (state_q == RD_WAIT) lat_q <= lat_q + 4'd1;
      if (r_hs) begin
        addr_q <= addr_nxt;
        beat_q <= beat_q + 9'd1;
        lat_q  <= '0;
      end
      if (load_rd) begin
        rdata_q <= fetch_bad ? '0 : fetch_word;
        rresp_q <= fetch_bad ? 2'b10 : 2'b00;
      end
      if (w_hs) begin
        addr_q <= addr_nxt;
        // Saturate so a runaway burst keeps counting as "past awlen".
        if (!beat_q[8]) beat_q <= beat_q + 9'd1;
        if (beat_over || wr_bad || (wlast != rd_last)) err_q <= 1'b1;
      end
    end
  end

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wstrb[i]) mem[word_idx(addr_q)][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rid   = id_q;
  assign rdata = rdata_q;
  assign rresp = rresp_q;
  assign rlast = rvalid && rd_last;
  assign bid   = id_q;
  assign bresp = err_q ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi4_burst_mem.sv
// tb/tb_axi4_burst_mem.sv - directed self-checking bench for axi4_burst_mem
module tb_axi4_burst_mem;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd_data[$];
  logic [1:0]  rd_resp[$];
  logic        rd_last[$];
  logic [3:0]  rd_id[$];
  int          rd_lat;
  int          rd_changed;
  logic [31:0] wq[$];
  logic [3:0]  sq[$];

  axi4_burst_mem #(
    .DATA_W(32), .ADDR_W(32), .ID_W(4), .DEPTH(4096), .BASE(32'h8000_0000), .READ_LAT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  function automatic logic sig(input int k);
    case (k)
      0:       return arready;
      1:       return awready;
      2:       return wready;
      3:       return rvalid;
      default: return bvalid;
    endcase
  endfunction

  // Called just after a negedge; returns at a negedge with the signal high or times out.
  task automatic wait_hi(input int k);
    int n = 0;
    #1;
    while (!sig(k) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!sig(k)) begin
      total++;
      bad++;
      $display("FAIL timeout sel=%0d got=0 want=1", k);
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size, input bit hold);
    int cyc;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete();
    rd_changed = 0;
    rd_lat = 0;
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    wait_hi(0);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      cyc = 1;
      while (!rvalid && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      if (b == 0) rd_lat = cyc;
      if (!rvalid) begin
        total++; bad++;
        $display("FAIL read_timeout beat=%0d got=0 want=1", b);
        return;
      end
      rd_data.push_back(rdata); rd_resp.push_back(rresp);
      rd_last.push_back(rlast); rd_id.push_back(rid);
      if (hold) begin
        @(negedge clk);
        if ({rvalid, rdata, rresp, rlast, rid} !== {1'b1, rd_data[$], rd_resp[$], rd_last[$], rd_id[$]})
          rd_changed++;
      end
      rready = 1'b1;
      @(posedge clk); @(negedge clk);
      rready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int nbeats, input int last_at,
                          output logic [1:0] resp, output logic [3:0] wr_bid);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    wait_hi(1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      wdata = wq[b]; wstrb = sq[b]; wlast = (b == last_at); wvalid = 1'b1;
      wait_hi(2);
      @(posedge clk); @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    wait_hi(4);
    resp = bresp; wr_bid = bid;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=000000", {arready, awready, wready, rvalid, rlast, bvalid});
    end
    total++;
    if ({rid, rresp, rdata, bid, bresp} !== 44'h0) begin
      bad++;
      $display("FAIL reset_data got=%h want=0", {rid, rresp, rdata, bid, bresp});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({arready, awready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=01", {arready, awready});
    end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    arid = 4'd1; araddr = BASE; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd2; awaddr = BASE; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    #1;
    total++;
    if ({arready, awready} !== 2'b10) begin
      bad++; $display("FAIL arb_first got=%b want=10", {arready, awready});
    end
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    wait_hi(3);
    @(posedge clk); @(negedge clk);
    rready = 1'b0; arid = 4'd3; arvalid = 1'b1;
    #1;
    total++;
    if ({arready, awready} !== 2'b01) begin
      bad++; $display("FAIL arb_second got=%b want=01", {arready, awready});
    end
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    wait_hi(2);
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    wait_hi(4);
    total++;
    if ({bid, bresp} !== {4'd2, 2'b00}) begin
      bad++; $display("FAIL arb_bresp got=%h want=%h", {bid, bresp}, {4'd2, 2'b00});
    end
    @(posedge clk); @(negedge clk);
    bready = 1'b0; awvalid = 1'b1;
    #1;
    total++;
    if ({arready, awready} !== 2'b10) begin
      bad++; $display("FAIL arb_third got=%b want=10", {arready, awready});
    end
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; rready = 1'b1;
    wait_hi(3);
    total++;
    if ({rid, rdata} !== {4'd3, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL arb_readback got=%h want=%h", {rid, rdata}, {4'd3, 32'hDEAD_BEEF});
    end
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic test_single_read();
    do_read(4'd3, BASE, 8'd0, 2'b01, 3'd2, 1'b0);
    total++;
    if (rd_lat !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", rd_lat); end
    if (rd_data.size() == 1) begin
      total++;
      if ({rd_id[0], rd_data[0], rd_last[0], rd_resp[0]} !== {4'd3, 32'hDEAD_BEEF, 1'b1, 2'b00}) begin
        bad++;
        $display("FAIL single_beat got=%h/%h/%b/%h want=3/deadbeef/1/0",
                 rd_id[0], rd_data[0], rd_last[0], rd_resp[0]);
      end
    end
  endtask

  task automatic test_incr_burst();
    logic [1:0] r; logic [3:0] i_d;
    wq = '{32'd1, 32'd2, 32'd3, 32'd4}; sq = '{4'hF, 4'hF, 4'hF, 4'hF};
    do_write(4'd6, BASE + 32'h10, 8'd3, 2'b01, 4, 3, r, i_d);
    total++;
    if ({i_d, r} !== {4'd6, 2'b00}) begin bad++; $display("FAIL incr_bresp got=%h want=18", {i_d, r}); end
    do_read(4'd7, BASE + 32'h10, 8'd3, 2'b01, 3'd2, 1'b1);
    total++;
    if (rd_data.size() !== 4) begin bad++; $display("FAIL incr_count got=%0d want=4", rd_data.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({rd_data[i], rd_last[i], rd_resp[i], rd_id[i]} !== {32'(i + 1), (i == 3), 2'b00, 4'd7}) begin
          bad++;
          $display("FAIL incr_beat%0d got=%h/%b/%h want=%h/%b/0", i, rd_data[i], rd_last[i], rd_resp[i],
                   32'(i + 1), (i == 3));
        end
      end
    end
    total++;
    if (rd_changed !== 0) begin bad++; $display("FAIL incr_stable got=%0d want=0", rd_changed); end
  endtask

  task automatic test_strobe_fixed();
    logic [1:0] r; logic [3:0] i_d;
    wq = '{32'h0000_AAAA, 32'hBBBB_0000}; sq = '{4'b0011, 4'b1100};
    do_write(4'd1, BASE, 8'd1, 2'b00, 2, 1, r, i_d);
    total++;
    if (r !== 2'b00) begin bad++; $display("FAIL fixed_bresp got=%h want=0", r); end
    do_read(4'd2, BASE, 8'd1, 2'b00, 3'd2, 1'b0);
    if (rd_data.size() == 2) begin
      total++;
      if ({rd_data[0], rd_data[1], rd_last[0], rd_last[1]} !== {32'hBBBB_AAAA, 32'hBBBB_AAAA, 2'b01}) begin
        bad++;
        $display("FAIL fixed_read got=%h,%h last=%b%b want=bbbbaaaa,bbbbaaaa last=01",
                 rd_data[0], rd_data[1], rd_last[0], rd_last[1]);
      end
    end else begin
      total++; bad++; $display("FAIL fixed_count got=%0d want=2", rd_data.size());
    end
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [3:0] i_d;
    do_read(4'd4, BASE + 32'h4000, 8'd0, 2'b01, 3'd2, 1'b0);
    total++;
    if (rd_data.size() != 1 || {rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL err_oob_read got=%0d beats want=1 beat resp=2 data=0", rd_data.size());
    end
    do_read(4'd4, BASE + 32'h3FFC, 8'd1, 2'b01, 3'd2, 1'b0);
    total++;
    if (rd_data.size() != 2 || {rd_resp[0], rd_resp[1], rd_data[1]} !== {2'b00, 2'b10, 32'h0}) begin
      bad++; $display("FAIL err_edge_read got=%0d beats want=2 beats resp=0,2 data1=0", rd_data.size());
    end
    do_read(4'd4, BASE - 32'd4, 8'd0, 2'b01, 3'd2, 1'b0);
    total++;
    if (rd_resp.size() != 1 || rd_resp[0] !== 2'b10) begin
      bad++; $display("FAIL err_below_base got=%0d beats want=1 beat resp=2", rd_resp.size());
    end
    do_read(4'd4, BASE + 32'h10, 8'd0, 2'b01, 3'd1, 1'b0);
    total++;
    if (rd_data.size() != 1 || {rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL err_size got=%0d beats want=1 beat resp=2 data=0", rd_data.size());
    end
    do_read(4'd4, BASE, 8'd0, 2'b11, 3'd2, 1'b0);
    total++;
    if (rd_data.size() != 1 || {rd_resp[0], rd_data[0]} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL err_reserved_burst got=%0d beats want=1 beat resp=2 data=0", rd_data.size());
    end
    wq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF}; sq = '{4'hF, 4'hF};
    do_write(4'd8, BASE + 32'h10, 8'd1, 2'b10, 2, 1, r, i_d);
    total++;
    if ({i_d, r} !== {4'd8, 2'b10}) begin bad++; $display("FAIL err_wrap_bresp got=%h want=22", {i_d, r}); end
    do_read(4'd9, BASE + 32'h10, 8'd1, 2'b01, 3'd2, 1'b0);
    total++;
    if (rd_data.size() != 2 || {rd_data[0], rd_data[1]} !== {32'd1, 32'd2}) begin
      bad++; $display("FAIL err_wrap_nowrite got=%0d beats want=2 beats data=1,2", rd_data.size());
    end
    wq = '{32'h11, 32'h22}; sq = '{4'hF, 4'hF};
    do_write(4'd10, BASE + 32'h20, 8'd3, 2'b01, 2, 1, r, i_d);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL err_early_wlast got=%h want=2", r); end
    wq = '{32'h55, 32'h66}; sq = '{4'hF, 4'hF};
    do_write(4'd11, BASE + 32'h30, 8'd0, 2'b01, 2, 1, r, i_d);
    total++;
    if (r !== 2'b10) begin bad++; $display("FAIL err_missing_wlast got=%h want=2", r); end
    do_read(4'd11, BASE + 32'h30, 8'd0, 2'b01, 3'd2, 1'b0);
    total++;
    if (rd_data.size() != 1 || {rd_data[0], rd_resp[0]} !== {32'h55, 2'b00}) begin
      bad++; $display("FAIL err_missing_wlast_mem got=%0d beats want=1 beat data=55", rd_data.size());
    end
  endtask

  task automatic test_reset_midburst();
    int beats = 0;
    int cyc = 0;
    @(negedge clk);
    arid = 4'd5; araddr = BASE + 32'h10; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    wait_hi(0);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    while (beats < 2 && cyc < 100) begin
      if (rvalid) beats++;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    rready = 1'b0;
    wait_hi(3);
    rst = 1'b1;
    #1;
    total++;
    if ({arready, awready, wready, rvalid, rlast, bvalid, rid, rresp, rdata, bid, bresp} !== 50'h0) begin
      bad++;
      $display("FAIL midburst_reset got=%b%b%b%b%b%b data=%h want=all zero",
               arready, awready, wready, rvalid, rlast, bvalid, {rid, rresp, rdata, bid, bresp});
    end
    @(negedge clk);
    rst = 1'b0;
    do_read(4'd12, BASE + 32'h10, 8'd0, 2'b01, 3'd2, 1'b0);
    total++;
    if (rd_data.size() != 1 || {rd_id[0], rd_data[0], rd_resp[0], rd_last[0]} !== {4'd12, 32'd1, 2'b00, 1'b1}) begin
      bad++; $display("FAIL midburst_recover got=%0d beats want=1 beat id=c data=1", rd_data.size());
    end
  endtask

  initial begin
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    test_reset();
    test_arbitration();
    test_single_read();
    test_incr_burst();
    test_strobe_fixed();
    test_errors();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_burst_mem.md
# axi4_burst_mem

AXI4 slave memory with a parametrised data width, depth, ID width and read latency. It supports FIXED and INCR bursts of up to 256 beats, byte strobes, ID echo and per-beat error responses. Read and write requests are served one transaction at a time, with fair arbitration between them. It is the burst-capable successor of the single-beat AXI-lite SRAM bridge, and sits behind the core's AXI4 crossbar as the simulation main memory.

## Interface
- DATA_W, 32: data width in bits; must be 32 or 64; BYTES = DATA_W/8
- ADDR_W, 32: address width
- ID_W, 4: AXI ID width
- DEPTH, 4096: memory size in DATA_W words
- BASE, 32'h8000_0000: byte address of word 0
- READ_LAT, 1: idle cycles before each read beat; range 0..15
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- arid/awid  in  ID_W  request ID
- araddr/awaddr  in  ADDR_W  start byte address
- arlen/awlen  in  8  beats-1
- arsize/awsize  in  3  log2 bytes per beat
- arburst/awburst  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arvalid/awvalid  in  1; arready/awready  out  1
- rid  out  ID_W; rdata  out  DATA_W; rresp  out  2; rlast  out  1; rvalid  out  1; rready  in  1
- wdata  in  DATA_W; wstrb  in  BYTES; wlast  in  1; wvalid  in  1; wready  out  1
- bid  out  ID_W; bresp  out  2; bvalid  out  1; bready  in  1

## Operation
- **States:** IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- **IDLE, request acceptance:**
  - arready = IDLE and grant_rd; awready = IDLE and not grant_rd.
  - grant_rd = arvalid and (not awvalid or prio_rd).
  - prio_rd resets to 1 and toggles after every accepted transaction, so simultaneous requests alternate read/write.
- **AR handshake:**
  - Latch arid, address, len and burst into registers; clear the beat counter.
  - Go to RD_WAIT, or straight to RD_DATA when READ_LAT=0.
- **RD_WAIT:** counts READ_LAT cycles, then goes to RD_DATA with rdata registered.
- **RD_DATA:**
  - rvalid=1; rid, rdata, rresp and rlast are held stable until rready.
  - rlast=1 on beat arlen.
  - On a non-last handshake: advance the address, then go to RD_WAIT (or RD_DATA with the next word when READ_LAT=0).
  - On the last handshake: go to IDLE.
- **Address rules:**
  - INCR adds BYTES per beat; FIXED repeats the same address.
  - The low log2(BYTES) address bits are ignored.
  - A beat is in range when addr>=BASE and (addr-BASE)>>log2(BYTES) < DEPTH.
  - 4 KB boundary crossing is not checked.
- **Error responses:**
  - A beat gets SLVERR (2'b10) if it is out of range, the burst is WRAP or 11, or size != log2(BYTES).
  - A SLVERR read beat returns rdata=0. Otherwise rresp=OKAY.
  - The full beat count is always returned, even when beats error.
- **AW handshake:** latch the same fields, go to WR_DATA; wready=1 only in WR_DATA.
  - W data offered before AW is held off, because wready is low in IDLE.
- **Write beats:**
  - Each W handshake writes bytes where wstrb[i]=1.
  - The write is suppressed if the beat is in error.
  - Beats after beat awlen are accepted and discarded, with the error flag set.
- **Ending a write burst:**
  - The burst ends on the wlast handshake, then goes to WR_RESP.
  - wlast before beat awlen, or missing wlast at beat awlen, sets the error flag.
- **WR_RESP:**
  - bvalid=1, bid=latched awid, bresp = SLVERR if the error flag is set, else OKAY.
  - On the bready handshake, go to IDLE.
- **Memory:** not initialised by reset; contents survive reset.

## Timing
- **Reset:** while rst=1, the state is IDLE and all outputs are 0: arready, awready, wready, rvalid, rlast, rdata, rid, rresp, bvalid, bid, bresp.
  - prio_rd=1 and the error flag and counters are cleared.
  - A reset mid-burst abandons the transaction with no response; a write beat already taken stays in memory.
- **Read latency:** AR handshake at edge T; first rvalid at T+1+READ_LAT.
  - Between beats there are READ_LAT idle cycles after each handshake.
  - READ_LAT=0 gives back-to-back beats under continuous rready.
- **Write timing:**
  - AW handshake at T: wready is high from T+1.
  - A wlast handshake at T': bvalid rises at T'+1.
  - Writes take effect at the handshake edge.
- **Return to IDLE:** one cycle after the last R or B handshake, at which point arready/awready may reassert.
- **Handshake rules:** valid never depends combinationally on ready; no output changes while valid=1 and ready=0.

## Test plan
- **Single read:** READ_LAT=1; preload word 0 = 32'hDEADBEEF; AR addr=32'h8000_0000, len=0, INCR, id=3 -> rvalid 2 cycles after the handshake, rdata=DEADBEEF, rid=3, rlast=1, rresp=0.
- **INCR write then read:** INCR write len=3 at 32'h8000_0010 with data 1..4 and wstrb=F, then a read of the same burst -> data 1,2,3,4 with rlast only on the 4th beat; bresp=0; rready toggled 1/0 keeps data stable.
- **Strobes and FIXED:** FIXED write len=1, beat0 wstrb=4'b0011 data 0000_AAAA, beat1 wstrb=4'b1100 data BBBB_0000 onto 0 -> a read returns BBBB_AAAA.
- **Errors:**
  - Read at 32'h8000_4000 (DEPTH=4096) -> rresp=2, rdata=0.
  - WRAP write len=1 -> bresp=2 and memory unchanged.
  - wlast on beat 1 of len=3 -> bresp=2.
- **Arbitration:** arvalid and awvalid both raised in the same cycle, twice in a row after reset -> read granted first, then write, then read.
- **Reset mid-burst:** assert rst during beat 2 of a len=7 read -> all outputs 0 immediately; after release, a new single read completes normally.
